// File: rtl/switch_input_buffer.sv
// -----------------------------------------------------------------------------
// switch_input_buffer
//
// Input side of one overlay switch port. Accepts a valid/ready stream from a
// neighbouring switch or PE, buffers it in a small FIFO and presents the head
// word to the five output muxes of the same switch (eager fork). The head is
// popped only once every output that claims this input (sel) has taken it.
// Outputs may take the word in different cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    upstream payload
//   in_valid   upstream word valid
//   in_ready   buffer can accept a word (from the count register only)
//   sel        claim lines from output muxes {S,W,E,N,NW}
//   dn_ready   per-output downstream ready, same order as sel
//   out_data   head-of-FIFO payload (zero when empty)
//   out_valid  per-output valid
//   count      FIFO occupancy
//   stall_cnt  (SWITCH_IN_STALL_CNT_EN only) saturating count of cycles
//              with a head word that did not pop
//
// Optional feature macro: SWITCH_IN_STALL_CNT_EN
// -----------------------------------------------------------------------------

// Per-output fork lane: tracks whether this output has already taken the
// current head word.
module switch_input_buffer_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic nonempty_i,
  input  logic sel_i,
  input  logic dn_ready_i,
  input  logic pop_i,
  output logic out_valid_o,
  output logic done_o
);
  logic taken_q, taken_d;
  logic fire;

  always_comb begin
    out_valid_o = nonempty_i & sel_i & ~taken_q;
    fire        = out_valid_o & dn_ready_i;
    // A dropped sel bit counts as done even if its stale taken bit is set.
    done_o      = ~sel_i | taken_q | fire;
    taken_d     = pop_i ? 1'b0 : (taken_q | fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taken_q <= 1'b0;
    else        taken_q <= taken_d;
  end
endmodule

module switch_input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        sel,
  input  logic [4:0]        dn_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_valid,
`ifdef SWITCH_IN_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [CNT_W-1:0]  count
);
  localparam int NUM_LANES = 5;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
    $error("switch_input_buffer: CNT_W must equal log2(DEPTH)+1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("switch_input_buffer: DEPTH must be a power of two >= 2");
  end

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic                 empty, push, pop;
  logic [NUM_LANES-1:0] done;

  // in_ready looks only at the registered count, so a pop while full does
  // not re-open the input until the following cycle.
  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & (sel != '0) & (&done);
  assign count    = count_q;
  assign out_data = empty ? '0 : mem_q[rd_ptr_q];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    switch_input_buffer_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .nonempty_i  (~empty),
      .sel_i       (sel[i]),
      .dn_ready_i  (dn_ready[i]),
      .pop_i       (pop),
      .out_valid_o (out_valid[i]),
      .done_o      (done[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef SWITCH_IN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (~empty & ~pop & (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif
endmodule
